// File: rtl/tob_publisher_pkg.sv
// Shared types and constants for the top-of-book publisher.
package tob_publisher_pkg;

  // One side of the book at the best price.
  typedef struct packed {
    logic [31:0] price;
    logic [63:0] shares;
  } bookLevelType;

  localparam int TOB_FRAME_BYTES = 29;
  localparam int SNAP_BITS       = 2 * $bits(bookLevelType);  // 192
  localparam int FRAME_BITS      = TOB_FRAME_BYTES * 8;       // 232

  // Snapshot ordering matches the wire order: buy price, buy shares, sell price, sell shares.
  function automatic logic [SNAP_BITS-1:0] packSnapshot(input bookLevelType buy,
                                                        input bookLevelType sell);
    return {buy.price, buy.shares, sell.price, sell.shares};
  endfunction

endpackage

// File: rtl/tob_publisher.sv
// Top-of-book publisher: whenever the best bid/ask differs from the last frame
// sent, emit one 29-byte big-endian frame, then hold off for GAP_CYCLES.
module tob_publisher
  import tob_publisher_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE   = 8'hA5,
  parameter int         GAP_CYCLES = 12
) (
  input  logic         clkIn,
  input  logic         rstBIn,
  input  bookLevelType topBuyIn,
  input  bookLevelType topSellIn,
  input  logic         txReadyIn,
  output logic [7:0]   txDataOut,
  output logic         txValidOut,
  output logic         txLastOut,
  output logic [31:0]  seqNumOut
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [4:0] LAST_IDX = 5'(TOB_FRAME_BYTES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [1:0]            state;
  logic [4:0]            byteIdx;
  logic [7:0]            gapCnt;
  logic [FRAME_BITS-1:0] frameBuf;
  logic [SNAP_BITS-1:0]  lastSent;
  logic [SNAP_BITS-1:0]  liveSnap;
  logic [31:0]           seqNum;
  logic                  change;
  logic                  handshake;

  assign liveSnap   = packSnapshot(topBuyIn, topSellIn);
  assign change     = (liveSnap != lastSent);
  assign handshake  = txValidOut && txReadyIn;

  // Outputs derive from registered state, so an async reset clears them at once.
  assign txValidOut = (state == ST_SEND);
  assign txDataOut  = frameBuf[FRAME_BITS-1 -: 8];
  assign txLastOut  = txValidOut && (byteIdx == LAST_IDX);
  assign seqNumOut  = seqNum;

  // Frame FSM: capture on change, shift bytes out on handshake, then idle gap.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state    <= ST_IDLE;
      byteIdx  <= '0;
      gapCnt   <= '0;
      // NOTE: the frame buffer is reset too, not left uninitialised, because
      // txDataOut reads its top byte directly and must be 0 during reset.
      frameBuf <= '0;
      lastSent <= '0;
      seqNum   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block sees the pre-edge value of the others (e.g. seqNum + 1 below).
      case (state)
        ST_IDLE: begin
          if (change) begin
            frameBuf <= {HDR_BYTE, seqNum + 32'd1, liveSnap};
            lastSent <= liveSnap;
            seqNum   <= seqNum + 32'd1;
            byteIdx  <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (handshake) begin
            frameBuf <= frameBuf << 8;
            if (byteIdx == LAST_IDX) begin
              byteIdx <= '0;
              gapCnt  <= '0;
              state   <= ST_GAP;
            end else begin
              byteIdx <= byteIdx + 5'd1;
            end
          end
        end
        ST_GAP: begin
          if (gapCnt == GAP_LAST) begin
            gapCnt <= '0;
            state  <= ST_IDLE;
          end else begin
            gapCnt <= gapCnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tob_publisher.sv
// Self-checking bench for tob_publisher: a frame-level reference model builds
// each expected byte stream from the book values with plain arithmetic.
module tb_tob_publisher;
  import tob_publisher_pkg::*;

  localparam int GAP = 12;

  logic         clkIn = 1'b0;
  logic         rstBIn;
  bookLevelType topBuy;
  bookLevelType topSell;
  logic         txReadyIn;
  logic [7:0]   txDataOut;
  logic         txValidOut;
  logic         txLastOut;
  logic [31:0]  seqNumOut;

  tob_publisher #(.HDR_BYTE(8'hA5), .GAP_CYCLES(GAP)) dut (
    .clkIn      (clkIn),
    .rstBIn     (rstBIn),
    .topBuyIn   (topBuy),
    .topSellIn  (topSell),
    .txReadyIn  (txReadyIn),
    .txDataOut  (txDataOut),
    .txValidOut (txValidOut),
    .txLastOut  (txLastOut),
    .seqNumOut  (seqNumOut)
  );

  always #2 clkIn = ~clkIn;

  int cycleCount = 0;
  always @(posedge clkIn) cycleCount <= cycleCount + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]  expSeq;
  bookLevelType lastBuy;
  bookLevelType lastSell;
  logic [7:0]   expFrame [TOB_FRAME_BYTES];

  // Results of the most recent captured frame
  int startCycle;
  int lastHsCycle;
  int hsCount;

  function automatic bookLevelType mkLevel(input logic [31:0] p, input logic [63:0] s);
    bookLevelType l;
    l.price  = p;
    l.shares = s;
    return l;
  endfunction

  function automatic bookLevelType randLevel();
    return mkLevel($urandom, {$urandom, $urandom});
  endfunction

  // Lay out the frame big-endian, field by field.
  task automatic buildExpected(input logic [31:0] seq, input bookLevelType b, input bookLevelType s);
    expFrame[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      expFrame[1 + i]  = 8'(seq     >> (24 - 8 * i));
      expFrame[5 + i]  = 8'(b.price >> (24 - 8 * i));
      expFrame[17 + i] = 8'(s.price >> (24 - 8 * i));
    end
    for (int i = 0; i < 8; i++) begin
      expFrame[9 + i]  = 8'(b.shares >> (56 - 8 * i));
      expFrame[21 + i] = 8'(s.shares >> (56 - 8 * i));
    end
  endtask

  // A frame is due whenever the book differs from what was last published.
  task automatic modelUpdate(input bookLevelType b, input bookLevelType s);
    if (b != lastBuy || s != lastSell) begin
      expSeq   = expSeq + 32'd1;
      lastBuy  = b;
      lastSell = s;
      buildExpected(expSeq, b, s);
    end
  endtask

  task automatic applyBook(input bookLevelType b, input bookLevelType s);
    @(negedge clkIn);
    topBuy  = b;
    topSell = s;
    modelUpdate(b, s);
  endtask

  task automatic modelReset();
    expSeq   = '0;
    lastBuy  = '0;
    lastSell = '0;
  endtask

  // Collect one frame. readyMode: 0 always ready, 1 toggle from first valid, 2 random.
  // With coalesce set, the book is changed after handshakes 5, 10 and 15.
  task automatic captureFrame(input int readyMode, input bit coalesce, input string name);
    logic [7:0] gotData [TOB_FRAME_BYTES];
    logic       gotLast [TOB_FRAME_BYTES];
    logic       prevValid, prevReady, prevLast, rdy, started, done;
    logic [7:0] prevData;
    int         budget;
    prevValid = 0; prevReady = 0; prevLast = 0; prevData = '0;
    started = 0; done = 0; budget = 0; hsCount = 0;
    startCycle = 0; lastHsCycle = 0;
    while (!done && budget < 2000) begin
      @(negedge clkIn);
      budget++;
      if (prevValid && !prevReady) begin
        checks++;
        if (txValidOut !== 1'b1 || txDataOut !== prevData || txLastOut !== prevLast) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b d=%02h l=%b want v=1 d=%02h l=%b",
                   name, txValidOut, txDataOut, txLastOut, prevData, prevLast);
        end
      end
      if (txValidOut === 1'b1 && !started) begin
        started    = 1;
        startCycle = cycleCount;
      end
      case (readyMode)
        1:       rdy = started ? ((cycleCount - startCycle) % 2 == 0) : 1'b1;
        2:       rdy = 1'($urandom % 2);
        default: rdy = 1'b1;
      endcase
      txReadyIn = rdy;
      if (txValidOut === 1'b1 && rdy) begin
        gotData[hsCount] = txDataOut;
        gotLast[hsCount] = txLastOut;
        hsCount++;
        if (txLastOut === 1'b1 || hsCount == TOB_FRAME_BYTES) begin
          done        = 1;
          lastHsCycle = cycleCount;
        end
        if (coalesce && (hsCount == 5 || hsCount == 10 || hsCount == 15)) begin
          topBuy  = randLevel();
          topSell = randLevel();
        end
      end
      prevValid = txValidOut; prevReady = rdy; prevData = txDataOut; prevLast = txLastOut;
    end
    @(negedge clkIn);
    txReadyIn = 1'b1;
    checks++;
    if (!done || hsCount != TOB_FRAME_BYTES) begin
      errors++;
      $display("FAIL %s frame_len: got %0d bytes (done=%0b) want %0d", name, hsCount, done, TOB_FRAME_BYTES);
    end
    for (int i = 0; i < hsCount; i++) begin
      checks++;
      if (gotData[i] !== expFrame[i] || gotLast[i] !== (i == TOB_FRAME_BYTES - 1)) begin
        errors++;
        $display("FAIL %s byte%0d: got %02h last=%b want %02h last=%b",
                 name, i, gotData[i], gotLast[i], expFrame[i], (i == TOB_FRAME_BYTES - 1));
      end
    end
    checks++;
    if (seqNumOut !== expSeq) begin
      errors++;
      $display("FAIL %s seqNumOut: got %08h want %08h", name, seqNumOut, expSeq);
    end
  endtask

  // Expect no valid byte for n cycles.
  task automatic checkIdle(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clkIn);
      if (txValidOut !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s idle: got %0d valid cycles want 0", name, seen);
    end
  endtask

  task automatic test_reset();
    rstBIn = 1'b0; txReadyIn = 1'b1; topBuy = '0; topSell = '0;
    modelReset();
    repeat (3) @(negedge clkIn);
    checks++;
    if (txValidOut !== 1'b0 || txLastOut !== 1'b0 || txDataOut !== 8'h00 || seqNumOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%02h seq=%08h want all zero",
               txValidOut, txLastOut, txDataOut, seqNumOut);
    end
    rstBIn = 1'b1;
    checkIdle(20, "reset_zero_book");
  endtask

  task automatic test_basic_frame();
    applyBook(mkLevel(32'd100, 64'd10), mkLevel(32'd101, 64'd20));
    captureFrame(0, 0, "basic");
    checkIdle(GAP + 10, "basic_after");
  endtask

  task automatic test_stall();
    applyBook(mkLevel(32'h0BAD_CAFE, 64'h0102_0304_0506_0708), mkLevel(32'hFFFF_FFFF, 64'hFEDC_BA98_7654_3210));
    captureFrame(1, 0, "stall");
    checks++;
    if (lastHsCycle - startCycle + 1 != 57) begin
      errors++;
      $display("FAIL stall_cycles: got %0d want 57", lastHsCycle - startCycle + 1);
    end
    checkIdle(GAP + 5, "stall_after");
  endtask

  task automatic test_coalesce();
    int prevLast;
    applyBook(randLevel(), randLevel());
    captureFrame(0, 1, "coalesce_first");
    prevLast = lastHsCycle;
    modelUpdate(topBuy, topSell);
    captureFrame(0, 0, "coalesce_second");
    checks++;
    if (startCycle - prevLast < GAP) begin
      errors++;
      $display("FAIL coalesce_gap: got %0d cycles want >= %0d", startCycle - prevLast, GAP);
    end
    checkIdle(GAP + 20, "coalesce_after");
  endtask

  task automatic test_revert();
    bookLevelType saved;
    applyBook(randLevel(), randLevel());
    captureFrame(0, 0, "revert_frame");
    saved = topBuy;
    topBuy.price = topBuy.price + 32'd1;
    repeat (3) @(negedge clkIn);
    topBuy = saved;
    checkIdle(40, "revert_after");
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int budget = 0;
    int lastSeen = 0;
    applyBook(randLevel(), randLevel());
    txReadyIn = 1'b1;
    while (n < 10 && budget < 200) begin
      @(negedge clkIn);
      budget++;
      if (txLastOut === 1'b1) lastSeen++;
      if (txValidOut === 1'b1) n++;
    end
    @(negedge clkIn);
    rstBIn = 1'b0;
    #1;
    checks++;
    if (n != 10 || lastSeen != 0 || txValidOut !== 1'b0 || txLastOut !== 1'b0 || seqNumOut !== 32'h0) begin
      errors++;
      $display("FAIL midreset: got bytes=%0d lastSeen=%0d v=%b l=%b seq=%08h want 10 0 0 0 0",
               n, lastSeen, txValidOut, txLastOut, seqNumOut);
    end
    @(negedge clkIn);
    rstBIn = 1'b1;
    modelReset();
    modelUpdate(topBuy, topSell);
    captureFrame(0, 0, "midreset_restart");
    checkIdle(GAP + 5, "midreset_after");
  endtask

  task automatic test_seq_wrap();
    @(negedge clkIn);
    force dut.seqNum = 32'hFFFF_FFFF;
    @(negedge clkIn);
    release dut.seqNum;
    expSeq = 32'hFFFF_FFFF;
    applyBook(randLevel(), randLevel());
    captureFrame(0, 0, "seq_wrap");
    checkIdle(GAP + 5, "seq_wrap_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      applyBook(randLevel(), randLevel());
      captureFrame(2, 0, "random");
      repeat (GAP + 2) @(negedge clkIn);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_coalesce();
    test_revert();
    test_reset_midframe();
    test_seq_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
